// File: rtl/iagc_acq_controller_pkg.sv
// Shared definitions for the IAGC acquisition controller: FSM states and
// the status word layout driven towards the decimator.
package iagc_acq_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ENABLE    = 3'd1,
    ST_WAIT_GATE = 3'd2,
    ST_ACQUIRE   = 3'd3,
    ST_DONE      = 3'd4,
    ST_ERROR     = 3'd5
  } state_t;

  localparam int STATUS_BIT_ENABLE = 0;
  localparam int STATUS_BIT_RUN    = 1;
  localparam int STATUS_BIT_DONE   = 2;
  localparam int STATUS_BIT_ERROR  = 3;

  localparam logic [3:0] STATUS_IDLE   = 4'b0000;
  localparam logic [3:0] STATUS_ENABLE = 4'(1 << STATUS_BIT_ENABLE);
  localparam logic [3:0] STATUS_RUN    = STATUS_ENABLE | 4'(1 << STATUS_BIT_RUN);
  localparam logic [3:0] STATUS_DONE   = 4'(1 << STATUS_BIT_DONE);
  localparam logic [3:0] STATUS_ERROR  = 4'(1 << STATUS_BIT_ERROR);

endpackage

// File: rtl/iagc_acq_controller_if.sv
// Host/front-end/decimator signal bundle for the acquisition controller.
interface iagc_acq_controller_if #(
  parameter int DECIMATOR_SIZE = 4,
  parameter int COUNT_SIZE     = 16,
  parameter int TIMEOUT_SIZE   = 20
);
  import iagc_acq_controller_pkg::*;

  // Control semantics: i_start is a one-cycle request honoured only from IDLE
  // or ERROR; i_abort is a level that wins over everything else in the cycle
  // it is sampled high; i_sample is a one-cycle strobe counted only in ACQUIRE.
  logic                      i_start;
  logic                      i_abort;
  logic [DECIMATOR_SIZE-1:0] i_decimator_cfg;
  logic [COUNT_SIZE-1:0]     i_n_samples;
  logic [TIMEOUT_SIZE-1:0]   i_timeout;
  logic                      i_gate;
  logic                      i_sample;

  logic [3:0]                o_iagc_status;
  logic [DECIMATOR_SIZE-1:0] o_decimator;
  logic [COUNT_SIZE-1:0]     o_sample_count;
  logic                      o_busy;
  logic                      o_done;
  state_t                    o_dbg_state;

  modport master (
    output i_start, i_abort, i_decimator_cfg, i_n_samples, i_timeout, i_gate, i_sample,
    input  o_iagc_status, o_decimator, o_sample_count, o_busy, o_done, o_dbg_state
  );

  modport slave (
    input  i_start, i_abort, i_decimator_cfg, i_n_samples, i_timeout, i_gate, i_sample,
    output o_iagc_status, o_decimator, o_sample_count, o_busy, o_done, o_dbg_state
  );

endinterface

// File: rtl/iagc_acq_controller_edge_detect.sv
// Registers a level and produces one-cycle rise/fall pulses from the
// registered copy and its previous value.
module iagc_acq_controller_edge_detect (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_sig,
  output logic o_rise,
  output logic o_fall
);

  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= i_sig;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/iagc_acq_controller.sv
// Sequences one IAGC acquisition: settle, wait for a gate rise, count
// decimated samples to the programmed total, report done or timeout.
module iagc_acq_controller
  import iagc_acq_controller_pkg::*;
#(
  parameter int DECIMATOR_SIZE = 4,
  parameter int COUNT_SIZE     = 16,
  parameter int TIMEOUT_SIZE   = 20,
  parameter int SETTLE_CYCLES  = 8
) (
  input  logic                    i_clock,
  input  logic                    i_reset_n,
  iagc_acq_controller_if.slave    bus
);

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  state_t                    r_state;
  logic [3:0]                r_status;
  logic [DECIMATOR_SIZE-1:0] r_decimator;
  logic [COUNT_SIZE-1:0]     r_count;
  logic                      r_busy;
  logic                      r_done;

  logic [COUNT_SIZE-1:0]     r_n;
  logic [TIMEOUT_SIZE-1:0]   r_timeout;
  logic [TIMEOUT_SIZE-1:0]   r_tmo_cnt;
  logic [SETTLE_W-1:0]       r_settle;
  logic [DECIMATOR_SIZE-1:0] r_cfg_seen;
  logic [DECIMATOR_SIZE-1:0] r_pend;
  logic                      r_pend_v;

  logic                      w_gate_rise;
  logic                      w_gate_fall;
  logic [DECIMATOR_SIZE-1:0] w_cfg_ratio;
  logic [COUNT_SIZE-1:0]     w_count_next;
  logic                      w_tmo_hit;

  iagc_acq_controller_edge_detect u_gate_edge (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_sig     (bus.i_gate),
    .o_rise    (w_gate_rise),
    .o_fall    (w_gate_fall)
  );

  // A ratio of zero would stall the decimator, so it is treated as one.
  assign w_cfg_ratio  = (bus.i_decimator_cfg == '0) ? DECIMATOR_SIZE'(1) : bus.i_decimator_cfg;
  assign w_count_next = r_count + COUNT_SIZE'(1);
  assign w_tmo_hit    = (r_timeout != '0) && (r_tmo_cnt == r_timeout - TIMEOUT_SIZE'(1));

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= ST_IDLE;
      r_status    <= STATUS_IDLE;
      r_decimator <= DECIMATOR_SIZE'(1);
      r_count     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_n         <= '0;
      r_timeout   <= '0;
      r_tmo_cnt   <= '0;
      r_settle    <= '0;
      r_cfg_seen  <= '0;
      r_pend      <= DECIMATOR_SIZE'(1);
      r_pend_v    <= 1'b0;
    end else begin
      r_done <= 1'b0;

      // A ratio change is only ever applied at the end of a gate window.
      if (w_gate_fall && r_pend_v) begin
        r_decimator <= r_pend;
        r_pend_v    <= 1'b0;
      end

      if (bus.i_abort) begin
        r_state  <= ST_IDLE;
        r_status <= STATUS_IDLE;
        r_busy   <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE, ST_ERROR: begin
            if (bus.i_start) begin
              r_state     <= ST_ENABLE;
              r_status    <= STATUS_ENABLE;
              r_busy      <= 1'b1;
              r_n         <= bus.i_n_samples;
              r_timeout   <= bus.i_timeout;
              r_count     <= '0;
              r_settle    <= '0;
              r_cfg_seen  <= bus.i_decimator_cfg;
              r_decimator <= w_cfg_ratio;
              r_pend_v    <= 1'b0;
            end
          end

          ST_ENABLE: begin
            if (r_settle == SETTLE_LAST) begin
              r_settle  <= '0;
              r_tmo_cnt <= '0;
              if (r_n == '0) begin
                r_state  <= ST_DONE;
                r_status <= STATUS_DONE;
                r_busy   <= 1'b0;
                r_done   <= 1'b1;
              end else begin
                r_state <= ST_WAIT_GATE;
              end
            end else begin
              r_settle <= r_settle + SETTLE_W'(1);
            end
          end

          ST_WAIT_GATE: begin
            if (w_tmo_hit) begin
              r_state  <= ST_ERROR;
              r_status <= STATUS_ERROR;
              r_busy   <= 1'b0;
            end else begin
              if (r_timeout != '0) begin
                r_tmo_cnt <= r_tmo_cnt + TIMEOUT_SIZE'(1);
              end
              if (w_gate_rise) begin
                r_state  <= ST_ACQUIRE;
                r_status <= STATUS_RUN;
              end
            end
          end

          ST_ACQUIRE: begin
            if (bus.i_sample) begin
              r_count <= w_count_next;
              if (w_count_next == r_n) begin
                r_state  <= ST_DONE;
                r_status <= STATUS_DONE;
                r_busy   <= 1'b0;
                r_done   <= 1'b1;
              end
            end
            if (bus.i_decimator_cfg != r_cfg_seen) begin
              r_cfg_seen <= bus.i_decimator_cfg;
              r_pend     <= w_cfg_ratio;
              r_pend_v   <= 1'b1;
            end
          end

          ST_DONE: begin
            r_state <= ST_IDLE;
          end

          default: begin
            r_state  <= ST_IDLE;
            r_status <= STATUS_IDLE;
            r_busy   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.o_iagc_status  = r_status;
  assign bus.o_decimator    = r_decimator;
  assign bus.o_sample_count = r_count;
  assign bus.o_busy         = r_busy;
  assign bus.o_done         = r_done;
  assign bus.o_dbg_state    = r_state;

endmodule
